// File: rtl/mem_dcache_pkg.sv
// Shared core types for the MEM-stage data cache: FSM state encoding,
// store-strobe helper and the decoded instruction record.
package mem_dcache_pkg;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        REFILL_REQ  = 3'd1,
        REFILL_DATA = 3'd2,
        WRITE_REQ   = 3'd3,
        WRITE_WAIT  = 3'd4
    } dc_state_e;

    typedef struct packed {
        logic [6:0] opcode;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [2:0] funct3;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] mem_wlen;
    } decoded_inst_t;

    // Strobe for a 2^wlen byte store at doubleword offset off; lanes past byte 7 are dropped.
    function automatic logic [7:0] wlen_to_strb(input logic [1:0] wlen, input logic [2:0] off);
        logic [15:0] mask;
        mask = (16'd1 << (5'd1 << wlen)) - 16'd1;
        mask = mask << off;
        return mask[7:0];
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Direct-mapped data/tag/valid storage: one write port, one asynchronous read port,
// byte-strobed data writes.
module dcache_array #(
    parameter int NUM_LINES  = 64,
    parameter int LINE_BEATS = 8,
    parameter int TAG_W      = 52,
    localparam int IDX_W     = $clog2(NUM_LINES),
    localparam int BW        = $clog2(LINE_BEATS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] rd_index,
    input  logic [BW-1:0]    rd_beat,
    output logic [63:0]      rd_data,
    output logic [TAG_W-1:0] rd_tag,
    output logic             rd_valid,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_index,
    input  logic [BW-1:0]    wr_beat,
    input  logic [63:0]      wr_data,
    input  logic [7:0]       wr_strb,
    input  logic             tag_we,
    input  logic [TAG_W-1:0] tag_value,
    input  logic             inval_all
);

    logic [63:0]          data_q [NUM_LINES*LINE_BEATS];
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [NUM_LINES-1:0] valid_q;

    assign rd_data  = data_q[{rd_index, rd_beat}];
    assign rd_tag   = tag_q[rd_index];
    assign rd_valid = valid_q[rd_index];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 8; b++) begin
                if (wr_strb[b]) begin
                    data_q[{wr_index, wr_beat}][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
        if (tag_we) begin
            tag_q[wr_index] <= tag_value;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q <= '0;
        end else if (inval_all) begin
            valid_q <= '0;
        end else if (tag_we) begin
            valid_q[wr_index] <= 1'b1;
        end
    end

endmodule

// File: rtl/mem_dcache.sv
// Blocking write-through, no-write-allocate direct-mapped data cache for the MEM stage.
// Downstream handshake: a request transfers on a cycle with mem_req_valid && mem_req_ready.
module mem_dcache
    import mem_dcache_pkg::*;
#(
    parameter int NUM_LINES  = 64,
    parameter int LINE_BEATS = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dc_en,
    input  logic [63:0] dc_in_addr,
    input  logic        dc_write_en,
    input  logic [63:0] dc_in_wdata,
    input  logic [1:0]  dc_in_wlen,
    output logic [63:0] dc_out_rdata,
    output logic        dc_out_rvalid,
    output logic        dc_out_write_done,
    input  logic        flush_all,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [63:0] mem_req_addr,
    output logic        mem_req_we,
    output logic [63:0] mem_req_wdata,
    output logic [7:0]  mem_req_wstrb,
    input  logic        mem_resp_valid,
    input  logic [63:0] mem_resp_data,
    output logic [2:0]  dbg_state_o
);

    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int BW    = $clog2(LINE_BEATS);
    localparam int OFF_W = BW + 3;
    localparam int TAG_W = 64 - OFF_W - IDX_W;

    dc_state_e   state_q, state_d;
    logic [BW-1:0] beat_q, beat_d;
    logic        flush_pend_q, flush_pend_d;
    logic        rvalid_q, rvalid_d;
    logic        wdone_q, wdone_d;
    logic [63:0] rdata_q, rdata_d;

    logic [IDX_W-1:0] req_index;
    logic [BW-1:0]    req_beat;
    logic [TAG_W-1:0] req_tag;
    logic [63:0]      arr_rd_data;
    logic [TAG_W-1:0] arr_rd_tag;
    logic             arr_rd_valid;
    logic             arr_wr_en;
    logic [BW-1:0]    arr_wr_beat;
    logic [63:0]      arr_wr_data;
    logic [7:0]       arr_wr_strb;
    logic             tag_we;
    logic             inval_all;
    logic             hit;
    logic [63:0]      store_data;
    logic [7:0]       store_strb;

    assign req_index  = dc_in_addr[OFF_W +: IDX_W];
    assign req_beat   = dc_in_addr[3 +: BW];
    assign req_tag    = dc_in_addr[63 -: TAG_W];
    assign hit        = arr_rd_valid && (arr_rd_tag == req_tag);
    assign store_data = dc_in_wdata << {dc_in_addr[2:0], 3'b000};
    assign store_strb = wlen_to_strb(dc_in_wlen, dc_in_addr[2:0]);

    dcache_array #(
        .NUM_LINES (NUM_LINES),
        .LINE_BEATS(LINE_BEATS),
        .TAG_W     (TAG_W)
    ) u_array (
        .clk      (clk),
        .reset    (reset),
        .rd_index (req_index),
        .rd_beat  (req_beat),
        .rd_data  (arr_rd_data),
        .rd_tag   (arr_rd_tag),
        .rd_valid (arr_rd_valid),
        .wr_en    (arr_wr_en),
        .wr_index (req_index),
        .wr_beat  (arr_wr_beat),
        .wr_data  (arr_wr_data),
        .wr_strb  (arr_wr_strb),
        .tag_we   (tag_we),
        .tag_value(req_tag),
        .inval_all(inval_all)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            beat_q       <= '0;
            flush_pend_q <= 1'b0;
            rvalid_q     <= 1'b0;
            wdone_q      <= 1'b0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            flush_pend_q <= flush_pend_d;
            rvalid_q     <= rvalid_d;
            wdone_q      <= wdone_d;
            rdata_q      <= rdata_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        beat_d        = beat_q;
        flush_pend_d  = flush_pend_q;
        rvalid_d      = 1'b0;
        wdone_d       = 1'b0;
        rdata_d       = rdata_q;
        inval_all     = 1'b0;
        arr_wr_en     = 1'b0;
        arr_wr_beat   = req_beat;
        arr_wr_data   = '0;
        arr_wr_strb   = '0;
        tag_we        = 1'b0;
        mem_req_valid = 1'b0;
        mem_req_we    = 1'b0;
        mem_req_addr  = {dc_in_addr[63:OFF_W], {OFF_W{1'b0}}};
        mem_req_wdata = '0;
        mem_req_wstrb = '0;

        case (state_q)
            IDLE: begin
                // A pending or simultaneous flush lands before the lookup, forcing a miss.
                inval_all    = flush_all || flush_pend_q;
                flush_pend_d = 1'b0;
                if (dc_en) begin
                    if (dc_write_en) begin
                        state_d = WRITE_REQ;
                    end else if (hit && !inval_all) begin
                        rvalid_d = 1'b1;
                        rdata_d  = arr_rd_data;
                    end else begin
                        state_d = REFILL_REQ;
                    end
                end
            end
            REFILL_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    beat_d  = '0;
                    state_d = REFILL_DATA;
                end
            end
            REFILL_DATA: begin
                if (mem_resp_valid) begin
                    arr_wr_en   = 1'b1;
                    arr_wr_beat = beat_q;
                    arr_wr_data = mem_resp_data;
                    arr_wr_strb = 8'hFF;
                    beat_d      = beat_q + 1'b1;
                    if (beat_q == BW'(LINE_BEATS - 1)) begin
                        tag_we   = 1'b1;
                        rvalid_d = 1'b1;
                        // The requested beat may be the one arriving right now.
                        rdata_d  = (req_beat == beat_q) ? mem_resp_data : arr_rd_data;
                        beat_d   = '0;
                        state_d  = IDLE;
                    end
                end
            end
            WRITE_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_we    = 1'b1;
                mem_req_addr  = {dc_in_addr[63:3], 3'b000};
                mem_req_wdata = store_data;
                mem_req_wstrb = store_strb;
                if (mem_req_ready) begin
                    if (hit) begin
                        arr_wr_en   = 1'b1;
                        arr_wr_data = store_data;
                        arr_wr_strb = store_strb;
                    end
                    state_d = WRITE_WAIT;
                end
            end
            WRITE_WAIT: begin
                if (mem_resp_valid) begin
                    wdone_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_q != IDLE && flush_all) begin
            flush_pend_d = 1'b1;
        end
    end

    assign dc_out_rdata      = rdata_q;
    assign dc_out_rvalid     = rvalid_q;
    assign dc_out_write_done = wdone_q;
    assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_mem_dcache.sv
// Directed bench for mem_dcache: the bench plays the downstream memory and checks
// each scenario against hand-computed values.
module tb_mem_dcache;

    localparam logic [2:0] ST_IDLE        = 3'd0;
    localparam logic [2:0] ST_REFILL_REQ  = 3'd1;
    localparam logic [2:0] ST_REFILL_DATA = 3'd2;
    localparam logic [2:0] ST_WRITE_REQ   = 3'd3;
    localparam logic [2:0] ST_WRITE_WAIT  = 3'd4;

    logic        clk = 1'b0;
    logic        reset;
    logic        dc_en;
    logic [63:0] dc_in_addr;
    logic        dc_write_en;
    logic [63:0] dc_in_wdata;
    logic [1:0]  dc_in_wlen;
    logic [63:0] dc_out_rdata;
    logic        dc_out_rvalid;
    logic        dc_out_write_done;
    logic        flush_all;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [63:0] mem_req_addr;
    logic        mem_req_we;
    logic [63:0] mem_req_wdata;
    logic [7:0]  mem_req_wstrb;
    logic        mem_resp_valid;
    logic [63:0] mem_resp_data;
    logic [2:0]  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    mem_dcache #(.NUM_LINES(64), .LINE_BEATS(8)) dut (
        .clk              (clk),
        .reset            (reset),
        .dc_en            (dc_en),
        .dc_in_addr       (dc_in_addr),
        .dc_write_en      (dc_write_en),
        .dc_in_wdata      (dc_in_wdata),
        .dc_in_wlen       (dc_in_wlen),
        .dc_out_rdata     (dc_out_rdata),
        .dc_out_rvalid    (dc_out_rvalid),
        .dc_out_write_done(dc_out_write_done),
        .flush_all        (flush_all),
        .mem_req_valid    (mem_req_valid),
        .mem_req_ready    (mem_req_ready),
        .mem_req_addr     (mem_req_addr),
        .mem_req_we       (mem_req_we),
        .mem_req_wdata    (mem_req_wdata),
        .mem_req_wstrb    (mem_req_wstrb),
        .mem_resp_valid   (mem_resp_valid),
        .mem_resp_data    (mem_resp_data),
        .dbg_state_o      (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    // Memory side of a refill: wait for the request, accept after one stalled cycle,
    // return beats base+0..base+7. flush_beat >= 0 pulses flush_all alongside that beat.
    // Returns on the negedge following the last beat.
    task automatic serve_refill(input logic [63:0] base, input int flush_beat,
                                output logic got, output logic [63:0] q_addr, output logic q_we);
        got = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (mem_req_valid) begin
                got = 1'b1;
                break;
            end
        end
        q_addr = mem_req_addr;
        q_we   = mem_req_we;
        if (got) begin
            mem_req_ready = 1'b1;
            @(negedge clk);
            mem_req_ready = 1'b0;
            for (int i = 0; i < 8; i++) begin
                mem_resp_valid = 1'b1;
                mem_resp_data  = base + 64'(i);
                flush_all      = (i == flush_beat);
                @(negedge clk);
            end
            mem_resp_valid = 1'b0;
            flush_all      = 1'b0;
        end
    endtask

    // Issue a store, capture the downstream request, accept it and acknowledge it.
    // Returns on the negedge where write_done should be high.
    task automatic do_store(input logic [63:0] a, input logic [63:0] d, input logic [1:0] wl,
                            output logic got, output logic [63:0] q_addr, output logic [63:0] q_wdata,
                            output logic [7:0] q_wstrb, output logic q_we);
        dc_en       = 1'b1;
        dc_write_en = 1'b1;
        dc_in_addr  = a;
        dc_in_wdata = d;
        dc_in_wlen  = wl;
        got = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (mem_req_valid) begin
                got = 1'b1;
                break;
            end
        end
        q_addr  = mem_req_addr;
        q_wdata = mem_req_wdata;
        q_wstrb = mem_req_wstrb;
        q_we    = mem_req_we;
        if (got) begin
            mem_req_ready = 1'b1;
            @(negedge clk);
            mem_req_ready  = 1'b0;
            mem_resp_valid = 1'b1;
            @(negedge clk);
            mem_resp_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        dc_en = 1'b0; dc_in_addr = '0; dc_write_en = 1'b0; dc_in_wdata = '0; dc_in_wlen = '0;
        flush_all = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({dc_out_rvalid, dc_out_write_done, mem_req_valid} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b required 000", {dc_out_rvalid, dc_out_write_done, mem_req_valid});
        end
        n_checks++;
        if (dc_out_rdata !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_rdata: got %h required 0", dc_out_rdata);
        end
        n_checks++;
        if (dbg_state !== ST_IDLE) begin
            n_fail++;
            $display("FAIL reset_state: got %0d required %0d", dbg_state, ST_IDLE);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_cold_refill();
        logic got; logic [63:0] qa; logic qwe;
        dc_en = 1'b1; dc_write_en = 1'b0; dc_in_addr = 64'h1000;
        @(negedge clk);
        n_checks++;
        if (mem_req_valid !== 1'b1 || dbg_state !== ST_REFILL_REQ) begin
            n_fail++;
            $display("FAIL cold_req_issue: valid=%b state=%0d required valid=1 state=%0d", mem_req_valid, dbg_state, ST_REFILL_REQ);
        end
        serve_refill(64'h10, -1, got, qa, qwe);
        n_checks++;
        if (got !== 1'b1 || qa !== 64'h1000 || qwe !== 1'b0) begin
            n_fail++;
            $display("FAIL cold_req_held: got=%b addr=%h we=%b required 1 0x1000 0", got, qa, qwe);
        end
        n_checks++;
        if (dc_out_rvalid !== 1'b1 || dc_out_rdata !== 64'h10 || dc_out_write_done !== 1'b0) begin
            n_fail++;
            $display("FAIL cold_rvalid: rvalid=%b rdata=%h wdone=%b required 1 0x10 0", dc_out_rvalid, dc_out_rdata, dc_out_write_done);
        end
        dc_en = 1'b0;
        @(negedge clk);
        n_checks++;
        if (dc_out_rvalid !== 1'b0 || dbg_state !== ST_IDLE) begin
            n_fail++;
            $display("FAIL cold_pulse_width: rvalid=%b state=%0d required 0 %0d", dc_out_rvalid, dbg_state, ST_IDLE);
        end
    endtask

    task automatic test_load_hit();
        logic [63:0] addrs [2];
        logic [63:0] exp   [2];
        addrs[0] = 64'h1008; exp[0] = 64'h11;
        addrs[1] = 64'h1038; exp[1] = 64'h17;
        for (int k = 0; k < 2; k++) begin
            dc_en = 1'b1; dc_write_en = 1'b0; dc_in_addr = addrs[k];
            @(negedge clk);
            n_checks++;
            if (dc_out_rvalid !== 1'b1 || dc_out_rdata !== exp[k] || mem_req_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL load_hit_%0d: rvalid=%b rdata=%h req=%b required 1 %h 0", k, dc_out_rvalid, dc_out_rdata, mem_req_valid, exp[k]);
            end
            dc_en = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_store_hit();
        logic got; logic [63:0] qa; logic [63:0] qd; logic [7:0] qs; logic qwe;
        do_store(64'h1003, 64'hAB, 2'd0, got, qa, qd, qs, qwe);
        n_checks++;
        if (got !== 1'b1 || qa !== 64'h1000 || qd !== 64'hAB00_0000 || qs !== 8'h08 || qwe !== 1'b1) begin
            n_fail++;
            $display("FAIL store_byte_req: got=%b addr=%h wdata=%h wstrb=%h we=%b required 1 0x1000 0xab000000 0x08 1", got, qa, qd, qs, qwe);
        end
        n_checks++;
        if (dc_out_write_done !== 1'b1 || dc_out_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL store_byte_done: wdone=%b rvalid=%b required 1 0", dc_out_write_done, dc_out_rvalid);
        end
        dc_en = 1'b0; dc_write_en = 1'b0;
        @(negedge clk);
        n_checks++;
        if (dc_out_write_done !== 1'b0) begin
            n_fail++;
            $display("FAIL store_done_width: wdone=%b required 0", dc_out_write_done);
        end
        dc_en = 1'b1; dc_in_addr = 64'h1000;
        @(negedge clk);
        n_checks++;
        if (dc_out_rvalid !== 1'b1 || dc_out_rdata !== 64'h0000_0000_AB00_0010) begin
            n_fail++;
            $display("FAIL store_byte_merge: rvalid=%b rdata=%h required 1 0x00000000ab000010", dc_out_rvalid, dc_out_rdata);
        end
        dc_en = 1'b0;
        @(negedge clk);
        do_store(64'h1008, 64'h1122_3344_5566_7788, 2'd3, got, qa, qd, qs, qwe);
        dc_en = 1'b0; dc_write_en = 1'b0;
        @(negedge clk);
        do_store(64'h100E, 64'hBEEF, 2'd1, got, qa, qd, qs, qwe);
        n_checks++;
        if (qa !== 64'h1008 || qd !== 64'hBEEF_0000_0000_0000 || qs !== 8'hC0) begin
            n_fail++;
            $display("FAIL store_half_req: addr=%h wdata=%h wstrb=%h required 0x1008 0xbeef000000000000 0xc0", qa, qd, qs);
        end
        dc_en = 1'b0; dc_write_en = 1'b0;
        @(negedge clk);
        dc_en = 1'b1; dc_in_addr = 64'h1008;
        @(negedge clk);
        n_checks++;
        if (dc_out_rvalid !== 1'b1 || dc_out_rdata !== 64'hBEEF_3344_5566_7788) begin
            n_fail++;
            $display("FAIL store_half_merge: rvalid=%b rdata=%h required 1 0xbeef334455667788", dc_out_rvalid, dc_out_rdata);
        end
        dc_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_store_miss();
        logic got; logic [63:0] qa; logic [63:0] qd; logic [7:0] qs; logic qwe;
        do_store(64'h9000, 64'hCAFE, 2'd3, got, qa, qd, qs, qwe);
        n_checks++;
        if (got !== 1'b1 || qa !== 64'h9000 || qd !== 64'hCAFE || qs !== 8'hFF || dc_out_write_done !== 1'b1) begin
            n_fail++;
            $display("FAIL store_miss_req: got=%b addr=%h wdata=%h wstrb=%h wdone=%b required 1 0x9000 0xcafe 0xff 1", got, qa, qd, qs, dc_out_write_done);
        end
        dc_en = 1'b0; dc_write_en = 1'b0;
        @(negedge clk);
        // Same index as 0x1000: the resident line must be untouched.
        dc_en = 1'b1; dc_in_addr = 64'h1000;
        @(negedge clk);
        n_checks++;
        if (dc_out_rvalid !== 1'b1 || dc_out_rdata !== 64'h0000_0000_AB00_0010 || mem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL store_miss_no_alloc: rvalid=%b rdata=%h req=%b required 1 0x00000000ab000010 0", dc_out_rvalid, dc_out_rdata, mem_req_valid);
        end
        dc_en = 1'b0;
        @(negedge clk);
        dc_en = 1'b1; dc_in_addr = 64'h9000;
        serve_refill(64'h90, -1, got, qa, qwe);
        n_checks++;
        if (got !== 1'b1 || qa !== 64'h9000 || dc_out_rvalid !== 1'b1 || dc_out_rdata !== 64'h90) begin
            n_fail++;
            $display("FAIL store_miss_then_refill: got=%b addr=%h rvalid=%b rdata=%h required 1 0x9000 1 0x90", got, qa, dc_out_rvalid, dc_out_rdata);
        end
        dc_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_flush();
        logic got; logic [63:0] qa; logic qwe;
        dc_en = 1'b1; dc_write_en = 1'b0; dc_in_addr = 64'h2040;
        serve_refill(64'h20, 3, got, qa, qwe);
        n_checks++;
        if (got !== 1'b1 || qa !== 64'h2040 || dc_out_rvalid !== 1'b1 || dc_out_rdata !== 64'h20) begin
            n_fail++;
            $display("FAIL flush_refill_completes: got=%b addr=%h rvalid=%b rdata=%h required 1 0x2040 1 0x20", got, qa, dc_out_rvalid, dc_out_rdata);
        end
        dc_en = 1'b0;
        @(negedge clk);
        dc_en = 1'b1;
        @(negedge clk);
        n_checks++;
        if (mem_req_valid !== 1'b1 || dc_out_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_next_miss: req=%b rvalid=%b required 1 0", mem_req_valid, dc_out_rvalid);
        end
        serve_refill(64'h40, -1, got, qa, qwe);
        dc_en = 1'b0;
        @(negedge clk);
        // Flush coinciding with a request to a resident line: served as a miss.
        flush_all = 1'b1; dc_en = 1'b1; dc_in_addr = 64'h2048;
        @(negedge clk);
        flush_all = 1'b0;
        n_checks++;
        if (mem_req_valid !== 1'b1 || dc_out_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_with_req_miss: req=%b rvalid=%b required 1 0", mem_req_valid, dc_out_rvalid);
        end
        serve_refill(64'h50, -1, got, qa, qwe);
        n_checks++;
        if (dc_out_rvalid !== 1'b1 || dc_out_rdata !== 64'h51) begin
            n_fail++;
            $display("FAIL flush_with_req_data: rvalid=%b rdata=%h required 1 0x51", dc_out_rvalid, dc_out_rdata);
        end
        dc_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_refill();
        logic got; logic stray_bad; logic [63:0] qa; logic qwe;
        dc_en = 1'b1; dc_write_en = 1'b0; dc_in_addr = 64'h3080;
        got = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (mem_req_valid) begin
                got = 1'b1;
                break;
            end
        end
        n_checks++;
        if (got !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_req: got=%b required 1", got);
        end
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mem_resp_valid = 1'b1; mem_resp_data = 64'h60 + 64'(i);
            @(negedge clk);
        end
        mem_resp_valid = 1'b1; mem_resp_data = 64'h63; reset = 1'b0; dc_en = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        stray_bad = 1'b0;
        for (int i = 4; i < 8; i++) begin
            mem_resp_data = 64'h60 + 64'(i);
            @(negedge clk);
            if (dc_out_rvalid !== 1'b0 || mem_req_valid !== 1'b0 || dbg_state !== ST_IDLE) stray_bad = 1'b1;
        end
        mem_resp_valid = 1'b0;
        n_checks++;
        if (stray_bad !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_stray_beats: disturbed=%b required 0", stray_bad);
        end
        dc_en = 1'b1; dc_in_addr = 64'h3080;
        serve_refill(64'h60, -1, got, qa, qwe);
        n_checks++;
        if (got !== 1'b1 || qa !== 64'h3080 || dc_out_rvalid !== 1'b1 || dc_out_rdata !== 64'h60) begin
            n_fail++;
            $display("FAIL reset_next_miss: got=%b addr=%h rvalid=%b rdata=%h required 1 0x3080 1 0x60", got, qa, dc_out_rvalid, dc_out_rdata);
        end
        dc_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic got; logic [63:0] qa; logic [63:0] qd; logic [7:0] qs; logic qwe;
        int pulses;
        pulses = 0;
        dc_en = 1'b1; dc_write_en = 1'b0; dc_in_addr = 64'h3088;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if (dc_out_rvalid === 1'b1 && dc_out_rdata === 64'h61) pulses++;
        end
        dc_en = 1'b0;
        @(negedge clk);
        n_checks++;
        if (pulses != 2 || dc_out_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL held_load_repeats: pulses=%0d rvalid_after=%b required 2 0", pulses, dc_out_rvalid);
        end
        // Atomic-style: load then store on the same held request.
        dc_en = 1'b1; dc_in_addr = 64'h3090;
        @(negedge clk);
        n_checks++;
        if (dc_out_rvalid !== 1'b1 || dc_out_rdata !== 64'h62) begin
            n_fail++;
            $display("FAIL atomic_load: rvalid=%b rdata=%h required 1 0x62", dc_out_rvalid, dc_out_rdata);
        end
        do_store(64'h3090, 64'h7, 2'd3, got, qa, qd, qs, qwe);
        n_checks++;
        if (got !== 1'b1 || qs !== 8'hFF || dc_out_write_done !== 1'b1 || dc_out_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL atomic_store: got=%b wstrb=%h wdone=%b rvalid=%b required 1 0xff 1 0", got, qs, dc_out_write_done, dc_out_rvalid);
        end
        dc_en = 1'b0; dc_write_en = 1'b0;
        @(negedge clk);
        dc_en = 1'b1;
        @(negedge clk);
        n_checks++;
        if (dc_out_rvalid !== 1'b1 || dc_out_rdata !== 64'h7) begin
            n_fail++;
            $display("FAIL atomic_readback: rvalid=%b rdata=%h required 1 0x7", dc_out_rvalid, dc_out_rdata);
        end
        dc_en = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_cold_refill();
        test_load_hit();
        test_store_hit();
        test_store_miss();
        test_flush();
        test_reset_mid_refill();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_dcache.md
MEM_DCACHE -- requirements
Module: mem_dcache

Interface
REQ-001 Parameters SHALL be: NUM_LINES, default 64, number of direct-mapped lines; LINE_BEATS, default 8, 64-bit beats per line (64 B line).
REQ-002 clk  input  1  sole clock, all state on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 dc_en  input  1  request valid; held stable with all request fields until its response.
REQ-005 dc_in_addr  input  64  byte address.
REQ-006 dc_write_en  input  1  1=store, 0=load.
REQ-007 dc_in_wdata  input  64  store data, right-justified (unshifted).
REQ-008 dc_in_wlen  input  2  log2 store bytes (0=1 B .. 3=8 B).
REQ-009 dc_out_rdata  output  64  full aligned doubleword containing dc_in_addr.
REQ-010 dc_out_rvalid  output  1  one-cycle load-complete pulse.
REQ-011 dc_out_write_done  output  1  one-cycle store-complete pulse.
REQ-012 flush_all  input  1  invalidate every line (sfence/fence.i).
REQ-013 mem_req_valid / mem_req_ready  output / input  1 / 1  downstream request handshake.
REQ-014 mem_req_addr  output  64  line-aligned (refill) or doubleword-aligned (write).
REQ-015 mem_req_we  output  1; mem_req_wdata  output  64; mem_req_wstrb  output  8.
REQ-016 mem_resp_valid  input  1; mem_resp_data  input  64: refill beats in order, or single write ack.

Function
REQ-017 Address split SHALL be offset[5:0], index[log2(NUM_LINES)+5:6], tag = remaining upper bits.
REQ-018 States SHALL be IDLE, REFILL_REQ, REFILL_DATA, WRITE_REQ, WRITE_WAIT.
REQ-019 Load hit in IDLE: dc_out_rvalid and dc_out_rdata SHALL be driven in the cycle after dc_en is first sampled (1-cycle latency).
REQ-020 Load miss: IDLE->REFILL_REQ; mem_req_valid held with we=0 until ready; ->REFILL_DATA; each mem_resp_valid writes beat counter slot 0..LINE_BEATS-1.
REQ-021 On final beat, line SHALL be marked valid with new tag and rvalid pulsed next cycle with the requested doubleword; ->IDLE.
REQ-022 Store (hit or miss): ->WRITE_REQ; wstrb = ((1<<(1<<wlen))-1) << addr[2:0]; wdata = dc_in_wdata << (8*addr[2:0]).
REQ-023 Store hit SHALL merge strobed bytes into the cached doubleword at handshake; miss SHALL NOT allocate (write-through, no-write-allocate).
REQ-024 WRITE_WAIT: on mem_resp_valid pulse dc_out_write_done, ->IDLE; store latency >=3 cycles.
REQ-025 rvalid and write_done SHALL never be high simultaneously and SHALL each last exactly one cycle.
REQ-026 A request still asserted after its response SHALL be treated as a new access (MEM atomics rely on load then store on held dc_en).
REQ-027 mem_resp_valid in IDLE/REFILL_REQ/WRITE_REQ SHALL be ignored.
REQ-028 flush_all SHALL clear all valid bits in one cycle when in IDLE; outside IDLE it SHALL be latched and applied on return to IDLE, and the completing refill's line is also invalidated.
REQ-029 flush_all and dc_en together in IDLE: flush first; request served as miss.
REQ-030 Misaligned stores crossing a doubleword are out of scope; strobe bits beyond bit 7 SHALL be dropped.

Reset
REQ-031 reset low SHALL force IDLE, clear all valid bits, beat counter, pending-flush flag; mem_req_valid, dc_out_rvalid, dc_out_write_done = 0; dc_out_rdata = 0.
REQ-032 Reset mid-refill or mid-write SHALL abandon the transaction; subsequent stray mem_resp_valid ignored per REQ-027.

Structure
REQ-033 State enum and wlen-to-strobe function SHALL live in the shared core package alongside decoded_inst_t.
REQ-034 Data/tag/valid storage SHALL be one sub-module dcache_array (1 write port, 1 async read port, byte-strobed data write).

Verification
REQ-035 Load 0x1000 cold -> one refill request addr 0x1000, 8 beats 0..7 = 0x10..0x17; rvalid with rdata 0x10 one cycle after last beat.
REQ-036 Repeat load 0x1008 -> rvalid next cycle, rdata 0x11, no mem_req_valid.
REQ-037 Store wlen=0 addr 0x1003 wdata 0xAB -> wstrb 0x08, wdata 0xAB000000; after ack load 0x1000 hits with byte3=0xAB.
REQ-038 Store addr 0x9000 miss -> write-through only; load 0x9000 then refills.
REQ-039 flush_all during refill -> completion rvalid still fires; next load same addr misses.
REQ-040 reset low during REFILL_DATA beat 3, then stray beats -> IDLE, no rvalid, next load misses.
